// File: rtl/exec_result_arbiter_if.sv
// exec_result_arbiter_if: bundles the functional-unit result ports and the
// common data bus (CDB) of the execute-to-commit result arbiter.
//
// Signal names keep the arbiter-relative direction suffix (_i = into the
// arbiter, _o = out of the arbiter) so they read the same on both sides.
//
// Parameters:
//   NUM_UNITS   number of functional-unit result ports
//   ROBsizeLog  ROB tag width
//
// Signals:
//   unitValid_i     per-unit result valid (each unit's valid_o)
//   unitVal_i       per-unit 64-bit result value
//   unitCommands_i  per-unit 10-bit command bits
//   unitTag_i       per-unit ROB tag
//   unitFlags_i     per-unit 4-bit flags
//   canGo_o         one-hot grant, drives each unit's canGo_i
//   cdbStall_i      ROB cannot accept the current CDB entry
//   cdbValid_o      CDB entry valid
//   cdbVal_o        CDB value
//   cdbCommands_o   CDB commands
//   cdbTag_o        CDB ROB tag
//   cdbFlags_o      CDB flags
//
// Modports:
//   slave   the arbiter itself
//   master  the environment (functional units + ROB)
interface exec_result_arbiter_if #(
    parameter int unsigned NUM_UNITS  = 4,
    parameter int unsigned ROBsizeLog = 4
);
    logic [NUM_UNITS-1:0]                 unitValid_i;
    logic [NUM_UNITS-1:0][63:0]           unitVal_i;
    logic [NUM_UNITS-1:0][9:0]            unitCommands_i;
    logic [NUM_UNITS-1:0][ROBsizeLog-1:0] unitTag_i;
    logic [NUM_UNITS-1:0][3:0]            unitFlags_i;
    logic [NUM_UNITS-1:0]                 canGo_o;

    logic                                 cdbStall_i;
    logic                                 cdbValid_o;
    logic [63:0]                          cdbVal_o;
    logic [9:0]                           cdbCommands_o;
    logic [ROBsizeLog-1:0]                cdbTag_o;
    logic [3:0]                           cdbFlags_o;

    modport slave (
        input  unitValid_i,
        input  unitVal_i,
        input  unitCommands_i,
        input  unitTag_i,
        input  unitFlags_i,
        output canGo_o,
        input  cdbStall_i,
        output cdbValid_o,
        output cdbVal_o,
        output cdbCommands_o,
        output cdbTag_o,
        output cdbFlags_o
    );

    modport master (
        output unitValid_i,
        output unitVal_i,
        output unitCommands_i,
        output unitTag_i,
        output unitFlags_i,
        input  canGo_o,
        output cdbStall_i,
        input  cdbValid_o,
        input  cdbVal_o,
        input  cdbCommands_o,
        input  cdbTag_o,
        input  cdbFlags_o
    );
endinterface

// File: rtl/exec_result_arbiter.sv
// exec_result_arbiter: consumer end of the functional-unit valid/canGo
// handshake. Picks one finished result per cycle and drives the registered
// common data bus toward the ROB and reservation stations.
//
// Ports:
//   clk_i    clock, all state updates on posedge
//   reset_i  asynchronous active-high reset
//   flush_i  kills the CDB entry and blocks grants this cycle
//   bus      exec_result_arbiter_if.slave: unit result ports, canGo grants,
//            CDB outputs and ROB stall
//
// Configuration macro:
//   EXEC_ARB_FIXED_PRIORITY_EN  when defined, lowest index always wins and the
//                               round-robin pointer is not built. Default
//                               (undefined) is round-robin.
module exec_result_arbiter #(
    parameter int unsigned NUM_UNITS  = 4,
    parameter int unsigned ROBsize    = 8,
    parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    exec_result_arbiter_if.slave  bus
);

    localparam int unsigned IdxW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic                  cdb_valid_q, cdb_valid_d;
    logic [63:0]           cdb_val_q, cdb_val_d;
    logic [9:0]            cdb_cmd_q, cdb_cmd_d;
    logic [ROBsizeLog-1:0] cdb_tag_q, cdb_tag_d;
    logic [3:0]            cdb_flags_q, cdb_flags_d;

    logic                  load;
    logic                  grant_found;
    logic [IdxW-1:0]       grant_idx;
    logic [NUM_UNITS-1:0]  can_go;

    // The CDB register accepts a new entry when it is empty or being drained.
    // Reset gating keeps canGo low while reset is held, since the cleared
    // register would otherwise look loadable.
    assign load = ~reset_i & ~flush_i & (~cdb_valid_q | ~bus.cdbStall_i);

`ifdef EXEC_ARB_FIXED_PRIORITY_EN

    // Scan downward so the last assignment is the lowest valid index.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = int'(NUM_UNITS) - 1; i >= 0; i--) begin
            if (bus.unitValid_i[IdxW'(i)]) begin
                grant_found = 1'b1;
                grant_idx   = IdxW'(i);
            end
        end
    end

`else

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] cand;

    // First valid unit at or above rr_q, wrapping past the top index.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            cand = IdxW'((32'(rr_q) + 32'(i)) % NUM_UNITS);
            if (!grant_found && bus.unitValid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (load && grant_found) begin
            rr_d = (grant_idx == IdxW'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

`endif

    always_comb begin
        can_go = '0;
        if (load && grant_found) begin
            can_go[grant_idx] = 1'b1;
        end
    end

    // Data fields only move on an actual grant; a flush clears valid alone.
    always_comb begin
        cdb_valid_d = cdb_valid_q;
        cdb_val_d   = cdb_val_q;
        cdb_cmd_d   = cdb_cmd_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_flags_d = cdb_flags_q;
        if (flush_i) begin
            cdb_valid_d = 1'b0;
        end else if (load) begin
            cdb_valid_d = grant_found;
            if (grant_found) begin
                cdb_val_d   = bus.unitVal_i[grant_idx];
                cdb_cmd_d   = bus.unitCommands_i[grant_idx];
                cdb_tag_d   = bus.unitTag_i[grant_idx];
                cdb_flags_d = bus.unitFlags_i[grant_idx];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cdb_valid_q <= 1'b0;
            cdb_val_q   <= '0;
            cdb_cmd_q   <= '0;
            cdb_tag_q   <= '0;
            cdb_flags_q <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_val_q   <= cdb_val_d;
            cdb_cmd_q   <= cdb_cmd_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_flags_q <= cdb_flags_d;
        end
    end

    assign bus.canGo_o       = can_go;
    assign bus.cdbValid_o    = cdb_valid_q;
    assign bus.cdbVal_o      = cdb_val_q;
    assign bus.cdbCommands_o = cdb_cmd_q;
    assign bus.cdbTag_o      = cdb_tag_q;
    assign bus.cdbFlags_o    = cdb_flags_q;

endmodule

// File: tb/tb_exec_result_arbiter.sv
// Directed testbench for exec_result_arbiter. Inputs change on the falling
// edge; canGo is sampled 1 time unit later, the CDB 1 time unit after the
// rising edge. A granted unit drops its valid right after the rising edge.
module tb_exec_result_arbiter;

    logic clk;
    logic rst;
    logic flush;
    int   total;
    int   bad;

    exec_result_arbiter_if #(.NUM_UNITS(4), .ROBsizeLog(4)) bus ();

    exec_result_arbiter #(
        .NUM_UNITS(4),
        .ROBsize(8)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .flush_i(flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Commands and flags are fixed per unit so a wrong-unit capture shows up.
    task automatic set_unit(input int u, input logic v, input logic [3:0] tag,
                            input logic [63:0] val);
        bus.unitValid_i[u]    = v;
        bus.unitTag_i[u]      = tag;
        bus.unitVal_i[u]      = val;
        bus.unitCommands_i[u] = 10'(u * 5 + 3);
        bus.unitFlags_i[u]    = 4'(u + 8);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        flush          = 1'b0;
        bus.cdbStall_i = 1'b0;
        for (int u = 0; u < 4; u++) set_unit(u, 1'b0, 4'd0, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int u = 0; u < 4; u++) set_unit(u, 1'b1, 4'(u + 1), 64'(u + 100));
        #1;
        total++; if (bus.canGo_o !== 4'b0000) begin bad++;
            $display("FAIL reset_cango got=%b want=0000", bus.canGo_o); end
        total++; if (bus.cdbValid_o !== 1'b0) begin bad++;
            $display("FAIL reset_valid got=%b want=0", bus.cdbValid_o); end
        total++; if (bus.cdbVal_o !== 64'd0) begin bad++;
            $display("FAIL reset_val got=%h want=0", bus.cdbVal_o); end
        total++; if (bus.cdbCommands_o !== 10'd0) begin bad++;
            $display("FAIL reset_cmd got=%h want=0", bus.cdbCommands_o); end
        total++; if (bus.cdbTag_o !== 4'd0) begin bad++;
            $display("FAIL reset_tag got=%h want=0", bus.cdbTag_o); end
        total++; if (bus.cdbFlags_o !== 4'd0) begin bad++;
            $display("FAIL reset_flags got=%h want=0", bus.cdbFlags_o); end
        @(posedge clk); #1;
        total++; if (bus.cdbValid_o !== 1'b0 || bus.canGo_o !== 4'b0000) begin bad++;
            $display("FAIL reset_held got valid=%b cango=%b want 0/0000",
                     bus.cdbValid_o, bus.canGo_o); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_unit(2, 1'b1, 4'd3, 64'd5);
        #1;
        total++; if (bus.canGo_o !== 4'b0100) begin bad++;
            $display("FAIL single_cango got=%b want=0100", bus.canGo_o); end
        @(posedge clk); #1;
        bus.unitValid_i[2] = 1'b0;
        total++; if (bus.cdbValid_o !== 1'b1) begin bad++;
            $display("FAIL single_valid got=%b want=1", bus.cdbValid_o); end
        total++; if (bus.cdbTag_o !== 4'd3) begin bad++;
            $display("FAIL single_tag got=%0d want=3", bus.cdbTag_o); end
        total++; if (bus.cdbVal_o !== 64'd5) begin bad++;
            $display("FAIL single_val got=%0d want=5", bus.cdbVal_o); end
        total++; if (bus.cdbCommands_o !== 10'd13 || bus.cdbFlags_o !== 4'd10) begin bad++;
            $display("FAIL single_cmdflags got=%0d/%0d want=13/10",
                     bus.cdbCommands_o, bus.cdbFlags_o); end
        @(negedge clk); #1;
        total++; if (bus.canGo_o !== 4'b0000) begin bad++;
            $display("FAIL single_idle_cango got=%b want=0000", bus.canGo_o); end
        @(posedge clk); #1;
        total++; if (bus.cdbValid_o !== 1'b0) begin bad++;
            $display("FAIL single_drain got=%b want=0", bus.cdbValid_o); end
        total++; if (bus.cdbTag_o !== 4'd3) begin bad++;
            $display("FAIL single_hold_tag got=%0d want=3", bus.cdbTag_o); end
        @(negedge clk);
    endtask

    task automatic test_all_four();
        logic [3:0] exp_go;
        do_reset();
        for (int u = 0; u < 4; u++) set_unit(u, 1'b1, 4'(u + 1), 64'(u + 160));
        for (int k = 0; k < 4; k++) begin
            exp_go = 4'b0001 << k;
            #1;
            total++; if (bus.canGo_o !== exp_go) begin bad++;
                $display("FAIL all4_cango[%0d] got=%b want=%b", k, bus.canGo_o, exp_go); end
            @(posedge clk); #1;
            bus.unitValid_i[k] = 1'b0;
            total++; if (bus.cdbValid_o !== 1'b1 || bus.cdbTag_o !== 4'(k + 1)) begin bad++;
                $display("FAIL all4_cdb[%0d] got valid=%b tag=%0d want 1/%0d",
                         k, bus.cdbValid_o, bus.cdbTag_o, k + 1); end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_unit(0, 1'b1, 4'd5, 64'h55);
        #1;
        total++; if (bus.canGo_o !== 4'b0001) begin bad++;
            $display("FAIL stall_first_cango got=%b want=0001", bus.canGo_o); end
        @(posedge clk); #1;
        bus.unitValid_i[0] = 1'b0;
        bus.cdbStall_i     = 1'b1;
        set_unit(1, 1'b1, 4'd6, 64'h66);
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (bus.canGo_o !== 4'b0000) begin bad++;
                $display("FAIL stall_cango[%0d] got=%b want=0000", c, bus.canGo_o); end
            @(posedge clk); #1;
            total++; if (bus.cdbValid_o !== 1'b1 || bus.cdbTag_o !== 4'd5 ||
                         bus.cdbVal_o !== 64'h55) begin bad++;
                $display("FAIL stall_hold[%0d] got valid=%b tag=%0d val=%h want 1/5/55",
                         c, bus.cdbValid_o, bus.cdbTag_o, bus.cdbVal_o); end
            @(negedge clk);
        end
        bus.cdbStall_i = 1'b0;
        #1;
        total++; if (bus.canGo_o !== 4'b0010) begin bad++;
            $display("FAIL stall_release_cango got=%b want=0010", bus.canGo_o); end
        @(posedge clk); #1;
        bus.unitValid_i[1] = 1'b0;
        total++; if (bus.cdbValid_o !== 1'b1 || bus.cdbTag_o !== 4'd6 ||
                     bus.cdbVal_o !== 64'h66) begin bad++;
            $display("FAIL stall_release_cdb got valid=%b tag=%0d val=%h want 1/6/66",
                     bus.cdbValid_o, bus.cdbTag_o, bus.cdbVal_o); end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int exp_u;
        do_reset();
        set_unit(0, 1'b1, 4'd1, 64'd10);
        set_unit(3, 1'b1, 4'd4, 64'd40);
        for (int k = 0; k < 4; k++) begin
`ifdef EXEC_ARB_FIXED_PRIORITY_EN
            exp_u = 0;
`else
            exp_u = (k % 2 == 0) ? 0 : 3;
`endif
            #1;
            total++; if (bus.canGo_o !== 4'(1 << exp_u)) begin bad++;
                $display("FAIL fair_cango[%0d] got=%b want unit %0d", k, bus.canGo_o, exp_u); end
            @(posedge clk); #1;
            total++; if (bus.cdbValid_o !== 1'b1 || bus.cdbTag_o !== 4'(exp_u + 1)) begin bad++;
                $display("FAIL fair_cdb[%0d] got valid=%b tag=%0d want 1/%0d",
                         k, bus.cdbValid_o, bus.cdbTag_o, exp_u + 1); end
            @(negedge clk);
        end
    endtask

    // Flush arrives together with a stall: flush must win and drop the entry.
    task automatic test_flush();
        do_reset();
        set_unit(2, 1'b1, 4'd7, 64'd77);
        #1;
        total++; if (bus.canGo_o !== 4'b0100) begin bad++;
            $display("FAIL flush_pre_cango got=%b want=0100", bus.canGo_o); end
        @(posedge clk); #1;
        bus.unitValid_i[2] = 1'b0;
        set_unit(0, 1'b1, 4'd1, 64'd11);
        flush          = 1'b1;
        bus.cdbStall_i = 1'b1;
        total++; if (bus.cdbValid_o !== 1'b1 || bus.cdbTag_o !== 4'd7) begin bad++;
            $display("FAIL flush_pre_cdb got valid=%b tag=%0d want 1/7",
                     bus.cdbValid_o, bus.cdbTag_o); end
        @(negedge clk); #1;
        total++; if (bus.canGo_o !== 4'b0000) begin bad++;
            $display("FAIL flush_cango got=%b want=0000", bus.canGo_o); end
        @(posedge clk); #1;
        flush          = 1'b0;
        bus.cdbStall_i = 1'b0;
        total++; if (bus.cdbValid_o !== 1'b0) begin bad++;
            $display("FAIL flush_valid got=%b want=0", bus.cdbValid_o); end
        total++; if (bus.cdbTag_o !== 4'd7 || bus.cdbVal_o !== 64'd77) begin bad++;
            $display("FAIL flush_data_hold got tag=%0d val=%0d want 7/77",
                     bus.cdbTag_o, bus.cdbVal_o); end
        @(negedge clk); #1;
        total++; if (bus.canGo_o !== 4'b0001) begin bad++;
            $display("FAIL flush_after_cango got=%b want=0001", bus.canGo_o); end
        @(posedge clk); #1;
        bus.unitValid_i[0] = 1'b0;
        total++; if (bus.cdbValid_o !== 1'b1 || bus.cdbTag_o !== 4'd1) begin bad++;
            $display("FAIL flush_after_cdb got valid=%b tag=%0d want 1/1",
                     bus.cdbValid_o, bus.cdbTag_o); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        do_reset();
        set_unit(1, 1'b1, 4'd2, 64'd22);
        set_unit(2, 1'b1, 4'd3, 64'd33);
        #1;
        total++; if (bus.canGo_o !== 4'b0010) begin bad++;
            $display("FAIL areset_pre_cango got=%b want=0010", bus.canGo_o); end
        @(posedge clk); #1;
        bus.unitValid_i[1] = 1'b0;
        bus.cdbStall_i     = 1'b1;
        total++; if (bus.cdbValid_o !== 1'b1 || bus.cdbTag_o !== 4'd2) begin bad++;
            $display("FAIL areset_pre_cdb got valid=%b tag=%0d want 1/2",
                     bus.cdbValid_o, bus.cdbTag_o); end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        total++; if (bus.cdbValid_o !== 1'b0 || bus.cdbTag_o !== 4'd0 ||
                     bus.cdbVal_o !== 64'd0 || bus.canGo_o !== 4'b0000) begin bad++;
            $display("FAIL areset_immediate got valid=%b tag=%0d val=%0d cango=%b want 0/0/0/0000",
                     bus.cdbValid_o, bus.cdbTag_o, bus.cdbVal_o, bus.canGo_o); end
        bus.cdbStall_i = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.cdbValid_o !== 1'b0 || bus.canGo_o !== 4'b0000) begin bad++;
            $display("FAIL areset_held got valid=%b cango=%b want 0/0000",
                     bus.cdbValid_o, bus.canGo_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus.canGo_o !== 4'b0100) begin bad++;
            $display("FAIL areset_after_cango got=%b want=0100", bus.canGo_o); end
        @(posedge clk); #1;
        bus.unitValid_i[2] = 1'b0;
        total++; if (bus.cdbValid_o !== 1'b1 || bus.cdbTag_o !== 4'd3) begin bad++;
            $display("FAIL areset_after_cdb got valid=%b tag=%0d want 1/3",
                     bus.cdbValid_o, bus.cdbTag_o); end
        @(negedge clk);
    endtask

    initial begin
        clk   = 1'b0;
        rst   = 1'b1;
        flush = 1'b0;
        total = 0;
        bad   = 0;
        bus.cdbStall_i = 1'b0;
        for (int u = 0; u < 4; u++) set_unit(u, 1'b0, 4'd0, 64'd0);
        @(negedge clk);
        test_reset();
        test_single();
        test_all_four();
        test_stall();
        test_fairness();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_result_arbiter.md
# exec_result_arbiter

Execute-to-commit result arbiter: the consumer end of the functional-unit `valid_o` / `canGo_i` handshake. It collects finished results from up to `NUM_UNITS` execute stages (ALU, multiplier, divider, memory), grants exactly one per cycle, and drives the single registered common data bus (CDB) toward the ROB and reservation stations. It is the block that generates each unit's `canGo_i` and honours ROB backpressure.

## Interface
- `NUM_UNITS`, 4: number of functional-unit result ports; unit 0 is the lowest index.
- `ROBsize`, 8: ROB entries.
- `ROBsizeLog`, `$clog2(ROBsize+1)`: tag width.
- `clk_i`  in  1  clock; all state updates on posedge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `flush_i`  in  1  pipeline flush; kills the CDB entry and blocks grants this cycle.
- `unitValid_i`  in  NUM_UNITS  per-unit result valid (unit's `valid_o`).
- `unitVal_i`  in  NUM_UNITS×64  per-unit result value.
- `unitCommands_i`  in  NUM_UNITS×10  per-unit command bits.
- `unitTag_i`  in  NUM_UNITS×ROBsizeLog  per-unit ROB tag.
- `unitFlags_i`  in  NUM_UNITS×4  per-unit flags.
- `canGo_o`  out  NUM_UNITS  one-hot grant; drives each unit's `canGo_i`.
- `cdbStall_i`  in  1  ROB cannot accept the current CDB entry.
- `cdbValid_o`  out  1  CDB entry valid.
- `cdbVal_o`  out  64  CDB value.
- `cdbCommands_o`  out  10  CDB commands.
- `cdbTag_o`  out  ROBsizeLog  CDB ROB tag.
- `cdbFlags_o`  out  4  CDB flags.

## Operation
- `load = ~flush_i & (~cdbValid_o | ~cdbStall_i)`; the CDB register may be written only when `load` is high.
- Grant selection (combinational): scanning from pointer `rr_r` upward with wrap, the first unit with `unitValid_i` set wins. `canGo_o[w] = load & unitValid_i[w]`; all other bits 0. `canGo_o` is never multi-hot.
- On posedge with `load`: `cdbValid_o <= |unitValid_i`; if a grant exists, capture the winner's val/commands/tag/flags; `rr_r <= (w+1) mod NUM_UNITS`. With no grant, data fields hold and `rr_r` holds.
- With `cdbValid_o & cdbStall_i & ~flush_i`: all CDB outputs hold, `canGo_o = 0`, and units stay in their done state.
- `flush_i`: next edge `cdbValid_o <= 0`, `rr_r` unchanged, `canGo_o = 0` in the flush cycle. Data fields hold their old values.
- Ungranted units keep `unitValid_i` high; no result is dropped or duplicated, and each granted result appears on the CDB exactly once.
- Inputs of unit u are sampled only in the cycle where `canGo_o[u]` = 1, matching the producer's eDone→eWaiting transition on `canGo_i`.

## Timing
- Reset (async): `cdbValid_o`=0, `cdbVal_o`=0, `cdbCommands_o`=0, `cdbTag_o`=0, `cdbFlags_o`=0, `rr_r`=0; `canGo_o`=0 while reset is held.
- Latency: grant in cycle N → `cdbValid_o` with that data in cycle N+1.
- Throughput: 1 result/cycle when `cdbStall_i`=0.
- `cdbStall_i` deasserting in cycle N with a waiting unit: grant in N and the new entry in N+1 (no bubble).
- `flush_i` and `cdbStall_i` together: flush wins and the entry is dropped.
- Reset mid-stall: all state clears immediately and no grant occurs until reset deasserts.

## Configuration
- `EXEC_ARB_FIXED_PRIORITY_EN`: when defined, selection is fixed priority with the lowest index winning, `rr_r` is removed, and all other behaviour is unchanged. When undefined, the round-robin scheme above applies (default build).

## Test plan
- Single producer: unit 2 valid with tag 3, val 5 → `canGo_o`=4'b0100 that cycle; next cycle `cdbValid_o`=1, tag 3, val 5; then `cdbValid_o`=0.
- All four units valid from reset → grants 0,1,2,3 over consecutive cycles; CDB shows each tag once, in order, with no idle cycle.
- Stall hold: entry valid, `cdbStall_i`=1 for 3 cycles with unit 1 waiting → CDB frozen and `canGo_o`=0; stall drops → grant unit 1 that cycle, its result on the CDB next cycle.
- Fairness: units 0 and 3 permanently valid → alternating grants 0,3,0,3.
- Flush with a valid entry and unit 0 waiting → `canGo_o`=0; next cycle `cdbValid_o`=0; the following cycle unit 0 is granted.
- Async reset asserted mid-stream between clock edges → outputs zero immediately; with `EXEC_ARB_FIXED_PRIORITY_EN`, units 0 and 3 valid → unit 0 is granted every time.
